// File: rtl/kd_tree_pkg.sv
// kd_tree_pkg: command codes, bus widths, controller states and error codes shared by the kd-tree blocks.
package kd_tree_pkg;
  localparam int COMMAND_SIZE = 5;
  localparam int DATA_SIZE = 24;
  localparam logic [COMMAND_SIZE-1:0] CMD_NOP = 5'h00;
  localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL = 5'h01;
  localparam logic [COMMAND_SIZE-1:0] CMD_CENTER_FILL_DONE = 5'h05;
  localparam logic [COMMAND_SIZE-1:0] CMD_START_SORTING = 5'h09;
  localparam logic [COMMAND_SIZE-1:0] CMD_DNE = 5'h10;
  localparam logic [COMMAND_SIZE-1:0] CMD_RST_DONE = 5'h1e;
  localparam logic [COMMAND_SIZE-1:0] CMD_RST = 5'h1f;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RST = 3'd1;
  localparam logic [2:0] S_FILL = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_SORT = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;
  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_RST_TO = 2'd2;
  localparam logic [1:0] ERR_FILL_TO = 2'd3;
endpackage

// File: rtl/kd_tree_watchdog.sv
// kd_tree_watchdog: counts enabled cycles since the last clear and pulses expire on the TIMEOUT-th one.
module kd_tree_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
  always_comb expire = enable && !clear && cnt == CW'(TIMEOUT - 1);
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else cnt <= clear ? '0 : enable ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/kd_tree_ctrl.sv
// kd_tree_ctrl: root-node sequencer (reset tree, stream centers, start sorting, settle); KD_CTRL_PERF_EN adds per-phase cycle counters.
module kd_tree_ctrl #(
  parameter int COMMAND_SIZE = kd_tree_pkg::COMMAND_SIZE,
  parameter int DATA_SIZE = kd_tree_pkg::DATA_SIZE,
  parameter int CENTER_NUM = 10,
  parameter int CNT_W = 27,
  parameter int SETTLE_CYCLES = 10,
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic [$clog2(CENTER_NUM+1)-1:0] num_centers,
  output logic ctr_rd,
  output logic [$clog2(CENTER_NUM)-1:0] ctr_addr,
  input  logic [DATA_SIZE-1:0] ctr_data,
  output logic [COMMAND_SIZE-1:0] tree_command,
  output logic [DATA_SIZE-1:0] tree_data,
  input  logic [COMMAND_SIZE-1:0] tree_command_up,
  output logic busy,
  output logic done,
  output logic error,
  output logic [1:0] err_code,
  output logic [$clog2(CENTER_NUM+1)-1:0] fill_count,
  output logic [CNT_W-1:0] cycle_count
`ifdef KD_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0] rst_cycles,
  output logic [CNT_W-1:0] fill_cycles,
  output logic [CNT_W-1:0] sort_cycles
`endif
);
  import kd_tree_pkg::*;
  localparam int NW = $clog2(CENTER_NUM + 1);
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  logic [2:0] st;
  logic [NW-1:0] num_r;
  logic [SW-1:0] settle;
  logic rd_v, accept, last, wd_en, wd_clr, expire;
  always_comb begin
    accept = st == S_IDLE && start && num_centers != '0 && num_centers <= NW'(CENTER_NUM);
    last = fill_count + 1'b1 == num_r;
    wd_en = st == S_RST || st == S_FILL || st == S_WAIT;
    wd_clr = !wd_en || (st == S_RST && tree_command_up == CMD_RST_DONE) || (st == S_FILL && rd_v && last);
  end
  kd_tree_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk(clk), .reset_n(reset_n), .clear(wd_clr), .enable(wd_en), .expire(expire)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cycle_count <= '0;
    else cycle_count <= cycle_count + 1'b1;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      st <= S_IDLE;
      tree_command <= CMD_NOP;
      tree_data <= '0;
      ctr_rd <= 1'b0;
      ctr_addr <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
      err_code <= ERR_NONE;
      fill_count <= '0;
      num_r <= '0;
      settle <= '0;
      rd_v <= 1'b0;
    end else begin
      done <= 1'b0;
      rd_v <= ctr_rd;
      case (st)
        S_IDLE: begin
          tree_command <= accept ? CMD_RST : CMD_NOP;
          if (accept) begin
            st <= S_RST;
            busy <= 1'b1;
            error <= 1'b0;
            err_code <= ERR_NONE;
            fill_count <= '0;
            num_r <= num_centers;
          end else if (start) begin
            error <= 1'b1;
            err_code <= ERR_COUNT;
          end
        end
        S_RST:
          if (tree_command_up == CMD_RST_DONE) begin
            st <= S_FILL;
            tree_command <= CMD_NOP;
            ctr_rd <= 1'b1;
            ctr_addr <= '0;
          end else if (expire) begin
            st <= S_IDLE;
            tree_command <= CMD_NOP;
            busy <= 1'b0;
            error <= 1'b1;
            err_code <= ERR_RST_TO;
          end
        S_FILL: begin
          tree_command <= CMD_NOP;
          if (ctr_rd) begin
            ctr_addr <= ctr_addr + 1'b1;
            ctr_rd <= NW'(ctr_addr) + 1'b1 < num_r;
          end
          // an early fill-done from the root drops any word still in flight
          if (tree_command_up == CMD_CENTER_FILL_DONE) begin
            st <= S_SORT;
            tree_command <= CMD_START_SORTING;
            ctr_rd <= 1'b0;
          end else if (rd_v) begin
            tree_command <= CMD_CENTER_FILL;
            tree_data <= ctr_data;
            fill_count <= fill_count + 1'b1;
            if (last) st <= S_WAIT;
          end else if (expire) begin
            st <= S_IDLE;
            ctr_rd <= 1'b0;
            busy <= 1'b0;
            error <= 1'b1;
            err_code <= ERR_FILL_TO;
          end
        end
        S_WAIT: begin
          tree_command <= CMD_NOP;
          if (tree_command_up == CMD_CENTER_FILL_DONE) begin
            st <= S_SORT;
            tree_command <= CMD_START_SORTING;
          end else if (expire) begin
            st <= S_IDLE;
            busy <= 1'b0;
            error <= 1'b1;
            err_code <= ERR_FILL_TO;
          end
        end
        S_SORT: begin
          st <= S_SETTLE;
          tree_command <= CMD_NOP;
          settle <= SW'(SETTLE_CYCLES);
        end
        S_SETTLE: begin
          settle <= settle - 1'b1;
          if (settle <= SW'(1)) begin
            st <= S_IDLE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
`ifdef KD_CTRL_PERF_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n || accept) begin
      rst_cycles <= '0;
      fill_cycles <= '0;
      sort_cycles <= '0;
    end else begin
      if (st == S_RST && !(&rst_cycles)) rst_cycles <= rst_cycles + 1'b1;
      if ((st == S_FILL || st == S_WAIT) && !(&fill_cycles)) fill_cycles <= fill_cycles + 1'b1;
      if ((st == S_SORT || st == S_SETTLE) && !(&sort_cycles)) sort_cycles <= sort_cycles + 1'b1;
    end
`endif
endmodule

// File: tb/tb_kd_tree_ctrl.sv
// tb_kd_tree_ctrl: table-driven runs against a stub root node and center memory, plus reset, busy-restart and counter-wrap sequences.
module tb_kd_tree_ctrl;
  import kd_tree_pkg::*;
  localparam int CN = 10, NW = 4, AW = 4, CW = 8, TO = 16;
  logic clk = 1'b0, reset_n = 1'b0, start = 1'b0, stub_clr = 1'b0;
  logic [NW-1:0] num_centers = '0;
  logic ctr_rd, busy, done, error;
  logic [AW-1:0] ctr_addr;
  logic [23:0] ctr_data = '0, tree_data;
  logic [4:0] tree_command, tree_command_up;
  logic [1:0] err_code;
  logic [NW-1:0] fill_count;
  logic [CW-1:0] cycle_count, c0;
`ifdef KD_CTRL_PERF_EN
  logic [CW-1:0] rst_cycles, fill_cycles, sort_cycles;
`endif
  always #5 clk = ~clk;
  kd_tree_ctrl #(.CENTER_NUM(CN), .CNT_W(CW), .SETTLE_CYCLES(10), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .num_centers(num_centers),
    .ctr_rd(ctr_rd), .ctr_addr(ctr_addr), .ctr_data(ctr_data),
    .tree_command(tree_command), .tree_data(tree_data), .tree_command_up(tree_command_up),
    .busy(busy), .done(done), .error(error), .err_code(err_code),
    .fill_count(fill_count), .cycle_count(cycle_count)
`ifdef KD_CTRL_PERF_EN
    , .rst_cycles(rst_cycles), .fill_cycles(fill_cycles), .sort_cycles(sort_cycles)
`endif
  );
  logic [23:0] mem [CN];
  always @(posedge clk) if (ctr_rd && ctr_addr < AW'(CN)) ctr_data <= mem[ctr_addr];
  // stub root: mode 0 nominal, 1 early fill-done, 2 silent, 3 never reports fill-done
  int mode = 2, early_n = 0, nexp = 0, rc = 0, fc = 0, dc = 0;
  always @(posedge clk)
    if (stub_clr) begin
      rc <= 0; fc <= 0; dc <= 0;
    end else begin
      rc <= tree_command == CMD_RST ? rc + 1 : 0;
      if (tree_command == CMD_CENTER_FILL) fc <= fc + 1;
      dc <= fc == nexp ? dc + 1 : 0;
    end
  assign tree_command_up =
    (mode != 2 && tree_command == CMD_RST && rc >= 3) ? CMD_RST_DONE :
    (mode == 0 && fc == nexp && dc >= 1) ? CMD_CENTER_FILL_DONE :
    (mode == 1 && tree_command == CMD_CENTER_FILL && fc == early_n - 1) ? CMD_CENTER_FILL_DONE : CMD_NOP;
  typedef struct {int num; int mode; int early; int fc; int err; int code; int beats; int rstc; int dn;} vec_t;
  vec_t tbl [8];
  logic [23:0] expq [$], gotq [$];
  int vec = 0, mis = 0;
  int beats, rstc, nonnop, ss, since, dlat, settle_bad;
  bit busy_seen, done_seen, in_settle;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    vec++;
    if (act !== exp) begin
      mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(negedge clk);
    if (tree_command == CMD_CENTER_FILL) begin gotq.push_back(tree_data); beats++; end
    if (tree_command == CMD_RST) rstc++;
    if (tree_command != CMD_NOP) nonnop++;
    if (busy) busy_seen = 1;
    if (done) done_seen = 1;
    if (tree_command == CMD_START_SORTING) begin ss++; since = 0; in_settle = 1; end
    else if (in_settle) begin
      since++;
      if (done) begin dlat = since; in_settle = 0; end
      else if (tree_command != CMD_NOP) settle_bad++;
    end
  endtask
  task automatic begin_run(vec_t v);
    mode = v.mode; early_n = v.early; nexp = v.num;
    expq.delete(); gotq.delete();
    beats = 0; rstc = 0; nonnop = 0; ss = 0; since = 0; dlat = -1; settle_bad = 0;
    busy_seen = 0; done_seen = 0; in_settle = 0;
    for (int i = 0; i < CN; i++) mem[i] = 24'($urandom);
    if (v.num >= 1 && v.num <= CN) for (int i = 0; i < v.num; i++) expq.push_back(mem[i]);
    stub_clr = 1'b1; start = 1'b1; num_centers = NW'(v.num);
    tick();
    stub_clr = 1'b0; start = 1'b0;
  endtask
  task automatic finish_run(vec_t v);
    int c;
    for (c = 0; c < 400; c++) begin
      if (done_seen || (error && !busy)) break;
      tick();
    end
    chk("run_terminates", 32'(c < 400), 1);
    repeat (3) tick();
    chk("error", 32'(error), v.err);
    chk("err_code", 32'(err_code), v.code);
    chk("fill_count", 32'(fill_count), v.fc);
    chk("busy_after", 32'(busy), 0);
    chk("cmd_idle_nop", 32'(tree_command), 32'(CMD_NOP));
    chk("fill_beats", beats, v.beats);
    chk("rst_cycles", rstc, v.rstc);
    chk("done_pulse", 32'(done_seen), v.dn);
    for (int i = 0; i < gotq.size() && i < expq.size(); i++) chk("fill_word", 32'(gotq[i]), 32'(expq[i]));
    if (v.dn != 0) begin
      chk("start_sorting_beats", ss, 1);
      chk("settle_then_done", dlat, 11);
      chk("settle_nops", settle_bad, 0);
    end
    if (v.num == 0 || v.num > CN) begin
      chk("bad_no_busy", 32'(busy_seen), 0);
      chk("bad_cmd_nop", nonnop, 0);
    end
  endtask
  task automatic chk_reset_outputs(string tag);
    chk({tag, "_cmd"}, 32'(tree_command), 32'(CMD_NOP));
    chk({tag, "_data"}, 32'(tree_data), 0);
    chk({tag, "_rd"}, 32'(ctr_rd), 0);
    chk({tag, "_addr"}, 32'(ctr_addr), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_error"}, 32'(error), 0);
    chk({tag, "_err_code"}, 32'(err_code), 0);
    chk({tag, "_fill_count"}, 32'(fill_count), 0);
    chk({tag, "_cycle_count"}, 32'(cycle_count), 0);
  endtask
  initial begin
    tbl[0] = '{10, 0, 0, 10, 0, 0, 10, 4, 1};
    tbl[1] = '{8, 1, 4, 4, 0, 0, 4, 4, 1};
    tbl[2] = '{0, 2, 0, 4, 1, 1, 0, 0, 0};
    tbl[3] = '{11, 2, 0, 4, 1, 1, 0, 0, 0};
    tbl[4] = '{3, 2, 0, 0, 1, 2, 0, 16, 0};
    tbl[5] = '{2, 3, 0, 2, 1, 3, 2, 4, 0};
    tbl[6] = '{1, 0, 0, 1, 0, 0, 1, 4, 1};
    tbl[7] = '{5, 1, 2, 2, 0, 0, 2, 4, 1};
    tick();
    chk_reset_outputs("reset");
    reset_n = 1'b1;
    tick();
    foreach (tbl[k]) begin
      begin_run(tbl[k]);
      finish_run(tbl[k]);
    end
    begin_run(tbl[0]);
    for (int c = 0; c < 100 && beats < 3; c++) tick();
    chk("reach_third_word", beats, 3);
    #2 reset_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    tick(); tick();
    reset_n = 1'b1;
    tick();
    begin_run(tbl[0]);
    finish_run(tbl[0]);
    begin_run(tbl[0]);
    for (int c = 0; c < 100 && beats < 2; c++) tick();
    chk("busy_in_fill", 32'(busy), 1);
    start = 1'b1; num_centers = 4'd3;
    tick();
    start = 1'b0;
    finish_run(tbl[0]);
    c0 = cycle_count;
    tick();
    chk("cycle_inc", 32'(cycle_count), 32'(CW'(c0 + 1'b1)));
    for (int c = 0; c < 300 && cycle_count != '1; c++) tick();
    chk("cycle_max", 32'(cycle_count), 32'(8'hff));
    tick();
    chk("cycle_wrap", 32'(cycle_count), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end
endmodule
